// File: rtl/tree_router_sync.sv
// Fat-tree router node: one parent port plus NCHILD child ports, per-input FIFOs,
// destination-digit routing and a round-robin arbiter feeding a registered stage per output.
module tree_router_sync #(
    parameter int NCHILD      = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 5,
    parameter int DEPTH       = 4,
    parameter int LEVEL       = 0,
    parameter int NODE_PREFIX = 0,
    parameter int IS_ROOT     = 0
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [ADDR_W+DATA_W-1:0]           p_in_data,
    input  logic                               p_in_valid,
    output logic                               p_in_ready,
    input  logic [NCHILD*(ADDR_W+DATA_W)-1:0]  c_in_data,
    input  logic [NCHILD-1:0]                  c_in_valid,
    output logic [NCHILD-1:0]                  c_in_ready,
    output logic [ADDR_W+DATA_W-1:0]           p_out_data,
    output logic                               p_out_valid,
    input  logic                               p_out_ready,
    output logic [NCHILD*(ADDR_W+DATA_W)-1:0]  c_out_data,
    output logic [NCHILD-1:0]                  c_out_valid,
    input  logic [NCHILD-1:0]                  c_out_ready
);
    localparam int W      = ADDR_W + DATA_W;
    localparam int CB     = $clog2(NCHILD);
    localparam int NIN    = NCHILD + 1;
    localparam int NOUT   = NCHILD + 1;
    localparam int IW     = $clog2(NIN);
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = ADDR_W - (LEVEL + 1) * CB;
    localparam int DIG_LO = DATA_W + LEVEL * CB;

    // Every port uses valid/ready: a flit moves on a rising CLK edge where both are high;
    // a raised output valid keeps itself and its data steady until that edge.
    // Index 0 is the parent on both the input and output side, 1..NCHILD are the children.
    logic [NIN-1:0][W-1:0]   w_in_data;
    logic [NIN-1:0]          w_in_valid;
    logic [NIN-1:0]          w_in_ready;
    logic [NIN-1:0]          w_push;
    logic [NIN-1:0]          w_pop;
    logic [NIN-1:0]          w_empty;
    logic [NIN-1:0]          w_full;
    logic [NIN-1:0]          w_pfx_ok;
    logic [NIN-1:0][W-1:0]   w_head;
    logic [NIN-1:0][IW-1:0]  w_route;

    logic [W-1:0]            r_mem [NIN][DEPTH];
    logic [AW-1:0]           r_wr  [NIN];
    logic [AW-1:0]           r_rd  [NIN];
    logic [AW:0]             r_cnt [NIN];

    logic [NOUT-1:0][NIN-1:0] w_gnt;
    logic [NOUT-1:0]          w_can_load;
    logic [NOUT-1:0]          w_load;
    logic [NOUT-1:0][W-1:0]   w_load_data;
    logic [NOUT-1:0][IW-1:0]  w_ptr_nxt;
    logic [NOUT-1:0][IW-1:0]  r_ptr;
    logic [NOUT-1:0]          w_out_ready;
    logic [NOUT-1:0]          r_out_valid;
    logic [NOUT-1:0][W-1:0]   r_out_data;

    assign w_in_data   = {c_in_data, p_in_data};
    assign w_in_valid  = {c_in_valid, p_in_valid};
    assign w_out_ready = {c_out_ready, p_out_ready};
    assign p_in_ready  = w_in_ready[0];
    assign c_in_ready  = w_in_ready[NIN-1:1];
    assign p_out_valid = r_out_valid[0];
    assign p_out_data  = r_out_data[0];
    assign c_out_valid = r_out_valid[NOUT-1:1];
    assign c_out_data  = r_out_data[NOUT-1:1];

    for (genvar i = 0; i < NIN; i++) begin : g_in
        logic [CB-1:0] w_digit;
        assign w_head[i]     = r_mem[i][r_rd[i]];
        assign w_empty[i]    = (r_cnt[i] == '0);
        assign w_full[i]     = (r_cnt[i] == (AW+1)'(DEPTH));
        assign w_in_ready[i] = !w_full[i] && !RESET;
        assign w_push[i]     = w_in_valid[i] && w_in_ready[i];
        assign w_digit       = w_head[i][DIG_LO +: CB];

        if (PW > 0) begin : g_pfx
            localparam logic [PW-1:0] PFX = PW'(NODE_PREFIX);
            assign w_pfx_ok[i] = (w_head[i][W-1 -: PW] == PFX);
        end else begin : g_nopfx
            assign w_pfx_ok[i] = 1'b1;
        end

        // Parent traffic always descends; child traffic climbs only when it leaves this subtree.
        assign w_route[i] = (i == 0 || IS_ROOT != 0 || w_pfx_ok[i])
                          ? IW'(w_digit) + IW'(1) : '0;
    end

    assign w_can_load = ~r_out_valid | w_out_ready;

    always_comb begin
        int idx;
        w_gnt       = '0;
        w_load      = '0;
        w_load_data = '0;
        w_ptr_nxt   = r_ptr;
        idx         = 0;
        for (int o = 0; o < NOUT; o++) begin
            for (int j = 0; j < NIN; j++) begin
                idx = (int'(r_ptr[o]) + j) % NIN;
                if (w_can_load[o] && !w_load[o] && !w_empty[idx] && w_route[idx] == IW'(o)) begin
                    w_gnt[o][idx]  = 1'b1;
                    w_load[o]      = 1'b1;
                    w_load_data[o] = w_head[idx];
                    w_ptr_nxt[o]   = IW'((idx + 1) % NIN);
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NOUT; o++) begin
            w_pop = w_pop | w_gnt[o];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NIN; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr[i]] <= w_in_data[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NIN; i++) begin
                r_wr[i]  <= '0;
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (w_push[i]) begin
                    r_wr[i] <= r_wr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rd[i] <= r_rd[i] + AW'(1);
                end
                r_cnt[i] <= r_cnt[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr       <= '0;
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            for (int o = 0; o < NOUT; o++) begin
                if (w_load[o]) begin
                    r_out_valid[o] <= 1'b1;
                    r_out_data[o]  <= w_load_data[o];
                end else if (w_out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tree_router_sync.sv
// Directed bench for tree_router_sync: a default node and a root node, with expected
// flits queued per output and a negedge monitor that pops and compares on every transfer.
module tb_tree_router_sync;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;

    logic [8:0]  p_in_data = '0;
    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [8:0]  c0_in_data = '0, c1_in_data = '0;
    logic        c0_in_valid = 1'b0, c1_in_valid = 1'b0;
    logic [1:0]  c_in_ready;
    logic [8:0]  p_out_data;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [17:0] c_out_data;
    logic [1:0]  c_out_valid;
    logic [1:0]  c_out_ready = 2'b11;

    logic [8:0]  rc0_in_data = '0;
    logic        rc0_in_valid = 1'b0;
    logic        rp_in_ready;
    logic [1:0]  rc_in_ready;
    logic [8:0]  rp_out_data;
    logic        rp_out_valid;
    logic [17:0] rc_out_data;
    logic [1:0]  rc_out_valid;

    int checks = 0;
    int failures = 0;
    bit root_p_seen = 1'b0;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [8:0] prev_d = '0;

    logic [8:0] exp_p[$];
    logic [8:0] exp_c0[$];
    logic [8:0] exp_c1[$];
    logic [8:0] exp_rc0[$];
    logic [8:0] exp_rc1[$];

    always #5 CLK = ~CLK;

    tree_router_sync dut (
        .CLK(CLK), .RESET(RESET),
        .p_in_data(p_in_data), .p_in_valid(p_in_valid), .p_in_ready(p_in_ready),
        .c_in_data({c1_in_data, c0_in_data}), .c_in_valid({c1_in_valid, c0_in_valid}),
        .c_in_ready(c_in_ready),
        .p_out_data(p_out_data), .p_out_valid(p_out_valid), .p_out_ready(p_out_ready),
        .c_out_data(c_out_data), .c_out_valid(c_out_valid), .c_out_ready(c_out_ready)
    );

    tree_router_sync #(.IS_ROOT(1)) dut_root (
        .CLK(CLK), .RESET(RESET),
        .p_in_data(9'h000), .p_in_valid(1'b0), .p_in_ready(rp_in_ready),
        .c_in_data({9'h000, rc0_in_data}), .c_in_valid({1'b0, rc0_in_valid}),
        .c_in_ready(rc_in_ready),
        .p_out_data(rp_out_data), .p_out_valid(rp_out_valid), .p_out_ready(1'b1),
        .c_out_data(rc_out_data), .c_out_valid(rc_out_valid), .c_out_ready(2'b11)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic mon(input string nm, input int qi, input logic v, input logic r,
                       input logic [8:0] d);
        logic [8:0] e;
        bit have;
        e = '0;
        have = 1'b0;
        if (v && r) begin
            case (qi)
                0: if (exp_p.size()   > 0) begin e = exp_p.pop_front();   have = 1'b1; end
                1: if (exp_c0.size()  > 0) begin e = exp_c0.pop_front();  have = 1'b1; end
                2: if (exp_c1.size()  > 0) begin e = exp_c1.pop_front();  have = 1'b1; end
                3: if (exp_rc0.size() > 0) begin e = exp_rc0.pop_front(); have = 1'b1; end
                default: if (exp_rc1.size() > 0) begin e = exp_rc1.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_%s actual=%0h expected=none", nm, d);
            end else begin
                chk({"out_", nm}, 32'(d), 32'(e));
            end
        end
    endtask

    // Monitor: all transfers are decided by values steady between negedge and posedge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    chk("p_hold_valid", 32'(p_out_valid), 32'd1);
                    chk("p_hold_data", 32'(p_out_data), 32'(prev_d));
                end
                prev_v = p_out_valid;
                prev_r = p_out_ready;
                prev_d = p_out_data;
                mon("p",   0, p_out_valid,    p_out_ready,    p_out_data);
                mon("c0",  1, c_out_valid[0], c_out_ready[0], c_out_data[8:0]);
                mon("c1",  2, c_out_valid[1], c_out_ready[1], c_out_data[17:9]);
                mon("rc0", 3, rc_out_valid[0], 1'b1,          rc_out_data[8:0]);
                mon("rc1", 4, rc_out_valid[1], 1'b1,          rc_out_data[17:9]);
                if (rp_out_valid) root_p_seen = 1'b1;
            end
        end
    end

    function automatic logic port_ready(input int port);
        case (port)
            0: return p_in_ready;
            1: return c_in_ready[0];
            2: return c_in_ready[1];
            default: return rc_in_ready[0];
        endcase
    endfunction

    task automatic set_port(input int port, input logic v, input logic [8:0] f);
        case (port)
            0: begin p_in_valid = v;   p_in_data = f;   end
            1: begin c0_in_valid = v;  c0_in_data = f;  end
            2: begin c1_in_valid = v;  c1_in_data = f;  end
            default: begin rc0_in_valid = v; rc0_in_data = f; end
        endcase
    endtask

    // Called just after a rising edge; returns just after the edge that took the flit.
    task automatic send(input int port, input logic [8:0] f);
        int n;
        n = 0;
        set_port(port, 1'b1, f);
        @(negedge CLK);
        while (!port_ready(port) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout port=%0d actual=stalled required=accepted", port);
        end
        @(posedge CLK);
        #1;
        set_port(port, 1'b0, 9'h000);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        exp_p.delete(); exp_c0.delete(); exp_c1.delete(); exp_rc0.delete(); exp_rc1.delete();
        @(negedge CLK);
        chk("rst_p_in_ready", 32'(p_in_ready), 32'd0);
        chk("rst_c_in_ready", 32'(c_in_ready), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_p_out_valid", 32'(p_out_valid), 32'd0);
        chk("post_rst_c_out_valid", 32'(c_out_valid), 32'd0);
        chk("post_rst_p_out_data", 32'(p_out_data), 32'd0);
        chk("post_rst_p_in_ready", 32'(p_in_ready), 32'd1);
        chk("post_rst_c_in_ready", 32'(c_in_ready), 32'd3);
        chk("post_rst_rc_out_valid", 32'(rc_out_valid), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        #1;
        do_reset();

        // Parent flit dest 0001 descends to child 1 after one extra edge.
        exp_c1.push_back(9'h02A);
        send(0, 9'h02A);
        @(negedge CLK);
        chk("lat_c1_valid_early", 32'(c_out_valid[1]), 32'd0);
        @(negedge CLK);
        chk("lat_c1_valid", 32'(c_out_valid[1]), 32'd1);
        chk("lat_c1_data", 32'(c_out_data[17:9]), 32'h02A);
        chk("lat_p_valid", 32'(p_out_valid), 32'd0);
        chk("lat_c0_valid", 32'(c_out_valid[0]), 32'd0);
        @(posedge CLK);
        #1;

        // Child 0: local destination goes down, foreign prefix goes up.
        exp_c1.push_back(9'h02B);
        exp_p.push_back(9'h08C);
        send(1, 9'h02B);
        send(1, 9'h08C);
        repeat (4) @(posedge CLK);
        #1;

        // Two children streaming upward share the parent output in strict alternation.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_p.push_back(9'h101 + 9'(k));
            exp_p.push_back(9'h111 + 9'(k));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) send(1, 9'h101 + 9'(k));
            end
            begin
                for (int k = 0; k < 4; k++) send(2, 9'h111 + 9'(k));
            end
        join
        repeat (6) @(posedge CLK);
        #1;

        // Backpressure: one flit in the output stage, four in the FIFO, the sixth stalls.
        p_out_ready = 1'b0;
        for (int k = 0; k < 6; k++) exp_p.push_back(9'h120 + 9'(k));
        for (int k = 0; k < 5; k++) send(1, 9'h120 + 9'(k));
        @(negedge CLK);
        chk("bp_c0_ready_full", 32'(c_in_ready[0]), 32'd0);
        fork
            send(1, 9'h125);
            begin
                repeat (4) begin
                    @(negedge CLK);
                    chk("bp_c0_ready_stall", 32'(c_in_ready[0]), 32'd0);
                    chk("bp_p_valid", 32'(p_out_valid), 32'd1);
                    chk("bp_p_data", 32'(p_out_data), 32'h120);
                end
                @(posedge CLK);
                #1;
                p_out_ready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge CLK);
                    chk("bp_drain_valid", 32'(p_out_valid), 32'd1);
                    chk("bp_drain_data", 32'(p_out_data), 32'(9'h120 + 9'(k)));
                end
            end
        join
        @(posedge CLK);
        #1;

        // Reset with flits buffered: nothing stale may appear afterwards.
        p_out_ready = 1'b0;
        send(1, 9'h140);
        send(1, 9'h141);
        send(1, 9'h142);
        do_reset();
        p_out_ready = 1'b1;
        repeat (10) @(posedge CLK);
        #1;

        // Root node: child 0 to dest 1001 stays down at child 1; the parent side never fires.
        exp_rc1.push_back(9'h133);
        send(3, 9'h133);
        repeat (4) @(posedge CLK);
        #1;

        n = 0;
        while ((exp_p.size() + exp_c0.size() + exp_c1.size() + exp_rc0.size()
                + exp_rc1.size()) > 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_exp_p", 32'(exp_p.size()), 32'd0);
        chk("drain_exp_c1", 32'(exp_c1.size()), 32'd0);
        chk("drain_exp_rc1", 32'(exp_rc1.size()), 32'd0);
        chk("root_p_never_valid", 32'(root_p_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
